uart_leds7_top: RTL and testbench

Top-level board block for the Cyclone V starter kit seven-segment demo. It receives 8N1 UART bytes on a single serial line and displays them as hexadecimal on four active-low seven-segment digits. HEX1:HEX0 show the newest byte and HEX3:HEX2 show the previous byte. The block sits directly between the board UART pin and the HEX display pins.

---
 rtl/uart_leds7_pkg.sv | 39 +++
 rtl/uart_leds7_top_rx_core.sv | 115 +++++++++++
 rtl/uart_leds7_top.sv | 53 +++++
 tb/tb_uart_leds7_top.sv | 129 ++++++++++++
 4 files changed

// File: rtl/uart_leds7_pkg.sv
// Shared types, bit-timing helpers and the seven-segment table for the UART hex display.
package uart_leds7_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

   function automatic int calc_bit_cycles(input int clk_mhz, input int bit_rate);
      return (clk_mhz * 1000000 + bit_rate / 2) / bit_rate;
   endfunction

   localparam int CLK_FREQ_DEF = 50;
   localparam int BIT_RATE_DEF = 115200;
   localparam int BIT_CYCLES   = calc_bit_cycles(CLK_FREQ_DEF, BIT_RATE_DEF);
   localparam int HALF         = BIT_CYCLES / 2;

   // active-low segments, bit order g,f,e,d,c,b,a
   function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0: seg = 7'b1000000;
         4'h1: seg = 7'b1111001;
         4'h2: seg = 7'b0100100;
         4'h3: seg = 7'b0110000;
         4'h4: seg = 7'b0011001;
         4'h5: seg = 7'b0010010;
         4'h6: seg = 7'b0000010;
         4'h7: seg = 7'b1111000;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0010000;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b0000011;
         4'hC: seg = 7'b1000110;
         4'hD: seg = 7'b0100001;
         4'hE: seg = 7'b0000110;
         default: seg = 7'b0001110;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/uart_leds7_top_rx_core.sv
// 8N1 UART receiver: 2-flop synchronizer, down-counter bit timer, one-clock valid strobe.
//
// state | meaning
// IDLE  | waiting for rx low (or, after a framing error, for rx high to re-arm)
// START | counting half a bit to confirm the start bit at its centre
// DATA  | sampling 8 data bits LSB first at bit centres
// STOP  | sampling the stop bit; high -> valid, low -> discard and disarm
module uart_rx_core
   import uart_leds7_pkg::*;
#(
   parameter int CLK_FREQ = 50,
   parameter int BIT_RATE = 115200
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid
);

   localparam int BC = calc_bit_cycles(CLK_FREQ, BIT_RATE);
   localparam int HC = BC / 2;
   localparam int CW = $clog2(BC + 1);
   localparam logic [CW-1:0] BIT_RELOAD  = CW'(BC - 1);
   localparam logic [CW-1:0] HALF_RELOAD = CW'(HC - 1);

   logic          rx_m, rx_s;
   rx_state_t     state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [2:0]    idx, idx_nx;
   logic [7:0]    sh, sh_nx;
   logic          armed, armed_nx;
   logic          valid_nx;
   logic          tc;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rx_m  <= 1'b1;
         rx_s  <= 1'b1;
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         sh    <= '0;
         armed <= 1'b1;
         valid <= 1'b0;
      end else begin
         rx_m  <= rx;
         rx_s  <= rx_m;
         state <= state_nx;
         cnt   <= cnt_nx;
         idx   <= idx_nx;
         sh    <= sh_nx;
         armed <= armed_nx;
         valid <= valid_nx;
      end
   end

   assign tc = (cnt == '0);

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      idx_nx   = idx;
      sh_nx    = sh;
      armed_nx = armed;
      valid_nx = 1'b0;
      case (state)
         IDLE: begin
            if (!armed) begin
               if (rx_s) armed_nx = 1'b1;
            end else if (!rx_s) begin
               state_nx = START;
               cnt_nx   = HALF_RELOAD;
            end
         end
         START: begin
            if (tc) begin
               if (!rx_s) begin
                  state_nx = DATA;
                  cnt_nx   = BIT_RELOAD;
                  idx_nx   = '0;
               end else begin
                  state_nx = IDLE;
               end
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         DATA: begin
            if (tc) begin
               sh_nx  = {rx_s, sh[7:1]};
               cnt_nx = BIT_RELOAD;
               if (idx == 3'd7) state_nx = STOP;
               else             idx_nx   = idx + 1'b1;
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         STOP: begin
            if (tc) begin
               state_nx = IDLE;
               // a low stop bit may be a break; do not restart until the line returns high
               if (rx_s) valid_nx = 1'b1;
               else      armed_nx = 1'b0;
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign data = sh;

endmodule

// File: rtl/uart_leds7_top.sv
// Board top: UART byte receiver feeding a two-byte history shown on four hex digits.
module uart_leds7_top
   import uart_leds7_pkg::*;
#(
   parameter int CLK_FREQ = 50,
   parameter int BIT_RATE = 115200
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       uart_rx,
   output logic [6:0] hex0,
   output logic [6:0] hex1,
   output logic [6:0] hex2,
   output logic [6:0] hex3
);

   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] newest, previous;

   uart_rx_core #(.CLK_FREQ(CLK_FREQ), .BIT_RATE(BIT_RATE)) u_rx (
      .clk    (clk),
      .resetn (resetn),
      .rx     (uart_rx),
      .data   (rx_data),
      .valid  (rx_valid)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         newest   <= 8'h00;
         previous <= 8'h00;
      end else if (rx_valid) begin
         previous <= newest;
         newest   <= rx_data;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hex0 <= 7'b1000000;
         hex1 <= 7'b1000000;
         hex2 <= 7'b1000000;
         hex3 <= 7'b1000000;
      end else begin
         hex0 <= seg7_decode(newest[3:0]);
         hex1 <= seg7_decode(newest[7:4]);
         hex2 <= seg7_decode(previous[3:0]);
         hex3 <= seg7_decode(previous[7:4]);
      end
   end

endmodule

// File: tb/tb_uart_leds7_top.sv
// Directed and random frames into the hex display; fast bit rate keeps the run short.
module tb_uart_leds7_top;

   localparam int BC = 16;  // 50 MHz / 3.125 Mbit/s

   logic       clk = 1'b0;
   logic       resetn;
   logic       uart_rx;
   logic [6:0] hex0, hex1, hex2, hex3;

   int n_cmp = 0;
   int n_bad = 0;

   logic [6:0] seg_ref [16];
   logic [7:0] m_new, m_prev;

   uart_leds7_top #(.CLK_FREQ(50), .BIT_RATE(3125000)) dut (
      .clk     (clk),
      .resetn  (resetn),
      .uart_rx (uart_rx),
      .hex0    (hex0),
      .hex1    (hex1),
      .hex2    (hex2),
      .hex3    (hex3)
   );

   always #10 clk = ~clk;

   task automatic check_val(input string tag, input logic [27:0] got, input logic [27:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [27:0] disp();
      return {hex3, hex2, hex1, hex0};
   endfunction

   function automatic logic [27:0] model_disp();
      return {seg_ref[m_prev[7:4]], seg_ref[m_prev[3:0]], seg_ref[m_new[7:4]], seg_ref[m_new[3:0]]};
   endfunction

   task automatic bit_time(input logic v, input int n);
      uart_rx = v;
      repeat (n * BC) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      bit_time(1'b0, 1);
      for (int i = 0; i < 8; i++) bit_time(b[i], 1);
      bit_time(stop, 1);
      uart_rx = 1'b1;
   endtask

   initial begin
      seg_ref[0]  = 7'b1000000; seg_ref[1]  = 7'b1111001;
      seg_ref[2]  = 7'b0100100; seg_ref[3]  = 7'b0110000;
      seg_ref[4]  = 7'b0011001; seg_ref[5]  = 7'b0010010;
      seg_ref[6]  = 7'b0000010; seg_ref[7]  = 7'b1111000;
      seg_ref[8]  = 7'b0000000; seg_ref[9]  = 7'b0010000;
      seg_ref[10] = 7'b0001000; seg_ref[11] = 7'b0000011;
      seg_ref[12] = 7'b1000110; seg_ref[13] = 7'b0100001;
      seg_ref[14] = 7'b0000110; seg_ref[15] = 7'b0001110;

      uart_rx = 1'b1;
      resetn  = 1'b0;
      #300;
      check_val("reset_low", disp(), {4{7'b1000000}});
      @(negedge clk);
      resetn = 1'b1;
      bit_time(1'b1, 3);
      check_val("reset_release", disp(), {4{7'b1000000}});

      send_frame(8'h5A, 1'b1);
      check_val("single_5A", disp(), {7'b1000000, 7'b1000000, 7'b0010010, 7'b0001000});

      bit_time(1'b1, 2);
      send_frame(8'h3C, 1'b1);
      check_val("b2b_first", disp(), {7'b0010010, 7'b0001000, 7'b0110000, 7'b1000110});
      send_frame(8'hF1, 1'b1);
      check_val("b2b_second", disp(), {7'b0110000, 7'b1000110, 7'b0001110, 7'b1111001});

      send_frame(8'h77, 1'b0);
      bit_time(1'b1, 2);
      check_val("frame_err", disp(), {7'b0110000, 7'b1000110, 7'b0001110, 7'b1111001});
      send_frame(8'h08, 1'b1);
      check_val("after_ferr", disp(), {7'b0001110, 7'b1111001, 7'b1000000, 7'b0000000});

      uart_rx = 1'b0;
      repeat (4) @(negedge clk);
      uart_rx = 1'b1;
      bit_time(1'b1, 3);
      check_val("glitch", disp(), {7'b0001110, 7'b1111001, 7'b1000000, 7'b0000000});
      send_frame(8'hB4, 1'b1);
      check_val("after_glitch", disp(), {7'b1000000, 7'b0000000, 7'b0000011, 7'b0011001});

      m_new  = 8'hB4;
      m_prev = 8'h08;
      for (int k = 0; k < 60; k++) begin
         logic [7:0] b;
         b = 8'($urandom_range(0, 255));
         bit_time(1'b1, $urandom_range(0, 30));
         if (k == 30) begin
            bit_time(1'b0, 1);
            for (int i = 0; i < 4; i++) bit_time(b[i], 1);
            resetn  = 1'b0;
            uart_rx = 1'b1;
            repeat (5) @(negedge clk);
            check_val("mid_reset", disp(), {4{7'b1000000}});
            resetn = 1'b1;
            bit_time(1'b1, 3);
            m_new  = 8'h00;
            m_prev = 8'h00;
            check_val("post_reset", disp(), model_disp());
         end else begin
            send_frame(b, 1'b1);
            m_prev = m_new;
            m_new  = b;
            check_val($sformatf("rand_%0d", k), disp(), model_disp());
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
